// File: rtl/instruction_fetch_window.sv
// instruction_fetch_window
// Consumer side of the 8-byte instruction prefetch queue. Owns the queue read
// pointer and the redirect strobe, strips V33 prefix bytes one per ce_1, and
// presents a byte-aligned window of opcode/operand bytes to the decoder.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// PREFIX | stripping prefix bytes at head; waits for a non-prefix byte
// READY  | prefixes done, window byte 0 is the opcode; waits for consume
module instruction_fetch_window #(
    parameter int          WINDOW   = 6,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_1,
    input  logic [63:0]           ipq,
    input  logic [3:0]            ipq_len,
    output logic [15:0]           ipq_head,
    output logic                  pfp_set,
    input  logic                  branch_req,
    input  logic [15:0]           branch_target,
    output logic [8*WINDOW-1:0]   win_bytes,
    output logic [3:0]            win_avail,
    output logic                  opcode_valid,
    input  logic                  consume,
    input  logic [2:0]            consume_len,
    output logic [15:0]           inst_pc,
    output logic                  seg_override,
    output logic [1:0]            seg_override_sreg,
    output logic [1:0]            rep_prefix,
    output logic                  buslock_prefix,
    output logic [2:0]            prefix_count,
    output logic                  implementation_fault
);

    // Segment register index encoding (sreg_index_e)
    localparam logic [1:0] SREG_DS1 = 2'd0;
    localparam logic [1:0] SREG_PS  = 2'd1;
    localparam logic [1:0] SREG_SS  = 2'd2;
    localparam logic [1:0] SREG_DS0 = 2'd3;

    localparam logic [3:0] WIN_MAX = 4'(WINDOW);

    typedef enum logic {PREFIX = 1'b0, READY = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [7:0] byte0;
    logic       is_prefix;
    logic       do_branch;
    logic       do_strip;
    logic       take;
    logic       len_bad;
    logic       do_retire;
    logic       do_fault;
    logic [15:0] head_next;

    // Window byte selection and availability; the window may straddle ipq[7]->ipq[0]
    always_comb begin
        logic [2:0] idx;
        win_bytes = '0;
        for (int i = 0; i < WINDOW; i++) begin
            idx = ipq_head[2:0] + 3'(i);
            win_bytes[8*i +: 8] = ipq[{idx, 3'b000} +: 8];
        end
        if (pfp_set)
            win_avail = 4'd0;
        else if (ipq_len < WIN_MAX)
            win_avail = ipq_len;
        else
            win_avail = WIN_MAX;
    end

    // Prefix classification of the byte at head and the qualified per-ce_1 events
    always_comb begin
        byte0 = ipq[{ipq_head[2:0], 3'b000} +: 8];
        case (byte0)
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3: is_prefix = 1'b1;
            default:                                          is_prefix = 1'b0;
        endcase
        do_branch = ce_1 & branch_req;
        do_strip  = ce_1 & ~branch_req & (state_q == PREFIX) & (win_avail != 4'd0) & is_prefix;
        take      = ce_1 & ~branch_req & opcode_valid & consume;
        len_bad   = (consume_len == 3'd0) | ({1'b0, consume_len} > win_avail);
        do_retire = take & ~len_bad;
        do_fault  = take & len_bad;
        head_next = ipq_head + {13'd0, consume_len};
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= PREFIX;
        else
            state_q <= state_d;
    end

    // FSM next-state logic; branch wins over everything else
    always_comb begin
        state_d = state_q;
        if (do_branch)
            state_d = PREFIX;
        else if (ce_1) begin
            case (state_q)
                PREFIX:  if (win_avail != 4'd0 && !is_prefix) state_d = READY;
                READY:   if (do_retire) state_d = PREFIX;
                default: state_d = PREFIX;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        opcode_valid = (state_q == READY) & (win_avail != 4'd0);
    end

    // Fetch pointer, instruction PC, redirect strobe and sticky fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipq_head             <= RESET_PC;
            inst_pc              <= RESET_PC;
            pfp_set              <= 1'b0;
            implementation_fault <= 1'b0;
        end else if (ce_1) begin
            pfp_set <= branch_req;
            if (do_branch) begin
                ipq_head <= branch_target;
                inst_pc  <= branch_target;
            end else if (do_retire) begin
                ipq_head <= head_next;
                inst_pc  <= head_next;
            end else if (do_strip) begin
                ipq_head <= ipq_head + 16'd1;
            end
            if (do_fault)
                implementation_fault <= 1'b1;
        end
    end

    // Latched prefix attributes; later segment / REP prefixes override earlier ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_override      <= 1'b0;
            seg_override_sreg <= SREG_DS1;
            rep_prefix        <= 2'b00;
            buslock_prefix    <= 1'b0;
            prefix_count      <= 3'd0;
        end else if (do_branch || do_retire) begin
            seg_override      <= 1'b0;
            seg_override_sreg <= SREG_DS1;
            rep_prefix        <= 2'b00;
            buslock_prefix    <= 1'b0;
            prefix_count      <= 3'd0;
        end else if (do_strip) begin
            if (prefix_count != 3'd7)
                prefix_count <= prefix_count + 3'd1;
            case (byte0)
                8'h26: begin seg_override <= 1'b1; seg_override_sreg <= SREG_DS1; end
                8'h2E: begin seg_override <= 1'b1; seg_override_sreg <= SREG_PS;  end
                8'h36: begin seg_override <= 1'b1; seg_override_sreg <= SREG_SS;  end
                8'h3E: begin seg_override <= 1'b1; seg_override_sreg <= SREG_DS0; end
                8'hF0: buslock_prefix <= 1'b1;
                8'hF2: rep_prefix     <= 2'b10;
                8'hF3: rep_prefix     <= 2'b11;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_window.sv
// Testbench for instruction_fetch_window: directed stimulus with expected
// values queued as each step is driven and compared once the step completes.
module tb_instruction_fetch_window;

    localparam int WINDOW = 6;

    localparam int S_HEAD = 0,  S_INST = 1,  S_PFP  = 2,  S_WA   = 3;
    localparam int S_OV   = 4,  S_SEG  = 5,  S_SREG = 6,  S_REP  = 7;
    localparam int S_BUS  = 8,  S_CNT  = 9,  S_FLT  = 10, S_WB   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                ce_1;
    logic [63:0]         ipq;
    logic [3:0]          ipq_len;
    logic [15:0]         ipq_head;
    logic                pfp_set;
    logic                branch_req;
    logic [15:0]         branch_target;
    logic [8*WINDOW-1:0] win_bytes;
    logic [3:0]          win_avail;
    logic                opcode_valid;
    logic                consume;
    logic [2:0]          consume_len;
    logic [15:0]         inst_pc;
    logic                seg_override;
    logic [1:0]          seg_override_sreg;
    logic [1:0]          rep_prefix;
    logic                buslock_prefix;
    logic [2:0]          prefix_count;
    logic                implementation_fault;

    logic [7:0] q [8];

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_window #(.WINDOW(WINDOW), .RESET_PC(16'h0000)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ce_1                 (ce_1),
        .ipq                  (ipq),
        .ipq_len              (ipq_len),
        .ipq_head             (ipq_head),
        .pfp_set              (pfp_set),
        .branch_req           (branch_req),
        .branch_target        (branch_target),
        .win_bytes            (win_bytes),
        .win_avail            (win_avail),
        .opcode_valid         (opcode_valid),
        .consume              (consume),
        .consume_len          (consume_len),
        .inst_pc              (inst_pc),
        .seg_override         (seg_override),
        .seg_override_sreg    (seg_override_sreg),
        .rep_prefix           (rep_prefix),
        .buslock_prefix       (buslock_prefix),
        .prefix_count         (prefix_count),
        .implementation_fault (implementation_fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) ipq[8*i +: 8] = q[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_HEAD: return 32'(ipq_head);
            S_INST: return 32'(inst_pc);
            S_PFP:  return 32'(pfp_set);
            S_WA:   return 32'(win_avail);
            S_OV:   return 32'(opcode_valid);
            S_SEG:  return 32'(seg_override);
            S_SREG: return 32'(seg_override_sreg);
            S_REP:  return 32'(rep_prefix);
            S_BUS:  return 32'(buslock_prefix);
            S_CNT:  return 32'(prefix_count);
            S_FLT:  return 32'(implementation_fault);
            default: return 32'(win_bytes[8*(sel-S_WB) +: 8]);
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // One clock period: inputs already driven, sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic expect_reset_state();
        expect_v("rst_head", S_HEAD, 0);
        expect_v("rst_inst", S_INST, 0);
        expect_v("rst_pfp",  S_PFP,  0);
        expect_v("rst_seg",  S_SEG,  0);
        expect_v("rst_sreg", S_SREG, 0);
        expect_v("rst_rep",  S_REP,  0);
        expect_v("rst_bus",  S_BUS,  0);
        expect_v("rst_cnt",  S_CNT,  0);
        expect_v("rst_flt",  S_FLT,  0);
        expect_v("rst_ov",   S_OV,   0);
    endtask

    initial begin
        reset = 1'b1;
        ce_1 = 1'b1;
        ipq_len = 4'd8;
        branch_req = 1'b0;
        branch_target = 16'h0;
        consume = 1'b0;
        consume_len = 3'd0;
        q[0] = 8'h2E; q[1] = 8'hF3; q[2] = 8'hA5; q[3] = 8'h11;
        q[4] = 8'h12; q[5] = 8'h13; q[6] = 8'h14; q[7] = 8'h15;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        expect_reset_state();
        expect_v("rst_wa", S_WA, 6);
        drain();

        // Prefixes 2E F3, then opcode A5
        expect_v("p1_head", S_HEAD, 1); expect_v("p1_seg", S_SEG, 1);
        expect_v("p1_sreg", S_SREG, 1); expect_v("p1_cnt", S_CNT, 1);
        step();
        expect_v("p2_head", S_HEAD, 2); expect_v("p2_rep", S_REP, 3);
        expect_v("p2_cnt", S_CNT, 2);   expect_v("p2_sreg", S_SREG, 1);
        step();
        ce_1 = 1'b0;
        expect_v("hold_head", S_HEAD, 2); expect_v("hold_ov", S_OV, 0);
        step();
        ce_1 = 1'b1;
        expect_v("op_ov", S_OV, 1); expect_v("op_wb0", S_WB + 0, 8'hA5);
        expect_v("op_inst", S_INST, 0); expect_v("op_head", S_HEAD, 2);
        step();

        // Retire 3 bytes
        consume = 1'b1; consume_len = 3'd3;
        expect_v("c3_head", S_HEAD, 5); expect_v("c3_inst", S_INST, 5);
        expect_v("c3_seg", S_SEG, 0);   expect_v("c3_rep", S_REP, 0);
        expect_v("c3_cnt", S_CNT, 0);   expect_v("c3_ov", S_OV, 0);
        expect_v("c3_wb0", S_WB + 0, 8'h13);
        step();
        consume = 1'b0;
        expect_v("r5_ov", S_OV, 1);
        step();
        consume = 1'b1; consume_len = 3'd1;
        expect_v("c1_head", S_HEAD, 6); expect_v("c1_inst", S_INST, 6);
        step();
        consume = 1'b0;

        // Window straddling ipq[7] -> ipq[0]
        ipq_len = 4'd4;
        #1;
        expect_v("wrap_wa", S_WA, 4);
        expect_v("wrap_wb0", S_WB + 0, 8'h14); expect_v("wrap_wb1", S_WB + 1, 8'h15);
        expect_v("wrap_wb2", S_WB + 2, 8'h2E); expect_v("wrap_wb3", S_WB + 3, 8'hF3);
        drain();
        expect_v("r6_ov", S_OV, 1);
        step();
        consume = 1'b1; consume_len = 3'd3;
        expect_v("c3w_head", S_HEAD, 9); expect_v("c3w_inst", S_INST, 9);
        expect_v("c3w_wb0", S_WB + 0, 8'hF3);
        step();
        consume = 1'b0;

        for (int i = 0; i < 8; i++) q[i] = 8'h90;
        q[2] = 8'h36;
        expect_v("r9_ov", S_OV, 1);
        step();

        // Over-length and zero-length consumes
        ipq_len = 4'd2;
        consume = 1'b1; consume_len = 3'd4;
        expect_v("f_flt", S_FLT, 1); expect_v("f_head", S_HEAD, 9); expect_v("f_ov", S_OV, 1);
        step();
        consume_len = 3'd0;
        expect_v("f0_flt", S_FLT, 1); expect_v("f0_head", S_HEAD, 9);
        step();
        consume_len = 3'd1;
        expect_v("c1b_head", S_HEAD, 10); expect_v("c1b_inst", S_INST, 10);
        expect_v("c1b_flt", S_FLT, 1);
        step();
        consume = 1'b0;
        expect_v("s36_head", S_HEAD, 11); expect_v("s36_seg", S_SEG, 1);
        expect_v("s36_sreg", S_SREG, 2); expect_v("s36_cnt", S_CNT, 1);
        step();

        // Branch with simultaneous consume, then a back-to-back branch
        branch_req = 1'b1; branch_target = 16'h1234; consume = 1'b1; consume_len = 3'd1;
        expect_v("b_head", S_HEAD, 16'h1234); expect_v("b_inst", S_INST, 16'h1234);
        expect_v("b_pfp", S_PFP, 1);  expect_v("b_wa", S_WA, 0);
        expect_v("b_seg", S_SEG, 0);  expect_v("b_cnt", S_CNT, 0);
        expect_v("b_ov", S_OV, 0);    expect_v("b_flt", S_FLT, 1);
        step();
        consume = 1'b0; branch_target = 16'h2000;
        expect_v("b2_head", S_HEAD, 16'h2000); expect_v("b2_inst", S_INST, 16'h2000);
        expect_v("b2_pfp", S_PFP, 1); expect_v("b2_wa", S_WA, 0);
        step();
        branch_req = 1'b0;

        // Prefix run 26 36 F0 fed one byte at a time
        q[0] = 8'h26; q[1] = 8'h36; q[2] = 8'hF0; q[3] = 8'h90;
        ipq_len = 4'd1;
        expect_v("pd_pfp", S_PFP, 0); expect_v("pd_head", S_HEAD, 16'h2000);
        expect_v("pd_wa", S_WA, 1);   expect_v("pd_cnt", S_CNT, 0);
        step();
        expect_v("r26_head", S_HEAD, 16'h2001); expect_v("r26_seg", S_SEG, 1);
        expect_v("r26_sreg", S_SREG, 0);        expect_v("r26_cnt", S_CNT, 1);
        step();
        ipq_len = 4'd0;
        expect_v("empty_head", S_HEAD, 16'h2001); expect_v("empty_wa", S_WA, 0);
        step();
        ipq_len = 4'd1;
        expect_v("r36_head", S_HEAD, 16'h2002); expect_v("r36_sreg", S_SREG, 2);
        expect_v("r36_cnt", S_CNT, 2);
        step();
        expect_v("rf0_head", S_HEAD, 16'h2003); expect_v("rf0_bus", S_BUS, 1);
        expect_v("rf0_cnt", S_CNT, 3);          expect_v("rf0_sreg", S_SREG, 2);
        step();
        expect_v("rop_ov", S_OV, 1); expect_v("rop_inst", S_INST, 16'h2000);
        expect_v("rop_head", S_HEAD, 16'h2003);
        step();

        // ipq_head wrap FFFFh -> 0000h
        ipq_len = 4'd8; branch_req = 1'b1; branch_target = 16'hFFFE;
        expect_v("bw_head", S_HEAD, 16'hFFFE); expect_v("bw_pfp", S_PFP, 1);
        step();
        branch_req = 1'b0;
        expect_v("bw_pfp0", S_PFP, 0);
        step();
        expect_v("bw_ov", S_OV, 1);
        step();
        consume = 1'b1; consume_len = 3'd3;
        expect_v("hw_head", S_HEAD, 16'h0001); expect_v("hw_inst", S_INST, 16'h0001);
        step();
        consume = 1'b0;
        q[1] = 8'hF2;
        expect_v("f2_head", S_HEAD, 2); expect_v("f2_rep", S_REP, 2); expect_v("f2_cnt", S_CNT, 1);
        step();

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        expect_reset_state();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
